// File: rtl/rsaasip_pkg.sv
// Shared types and default sizes for the 16-bit RSA ASIP pipeline.
package rsaasip_pkg;

    localparam int ARQ_DEF              = 16;
    localparam int MEMORY_ADDR_SIZE_DEF = 13;
    localparam int REG_ADDR_DEF         = 4;
    localparam int MEM_TIMEOUT_DEF      = 15;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_ALU   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_STORE = 2'b11
    } mem_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WB   = 2'b10
    } state_t;

endpackage

// File: rtl/mem_wb_holdreg.sv
// Capture register for an accepted EXE result: op, memory address, store data and rd.
module mem_wb_holdreg
    import rsaasip_pkg::*;
#(
    parameter int ARQ              = ARQ_DEF,
    parameter int MEMORY_ADDR_SIZE = MEMORY_ADDR_SIZE_DEF,
    parameter int REG_ADDR         = REG_ADDR_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_en_i,
    input  mem_op_t                     op_i,
    input  logic [MEMORY_ADDR_SIZE-1:0] addr_i,
    input  logic [ARQ-1:0]              data_i,
    input  logic [REG_ADDR-1:0]         rd_i,
    output mem_op_t                     op_o,
    output logic [MEMORY_ADDR_SIZE-1:0] addr_o,
    output logic [ARQ-1:0]              data_o,
    output logic [REG_ADDR-1:0]         rd_o
);

    mem_op_t                     op_q;
    logic [MEMORY_ADDR_SIZE-1:0] addr_q;
    logic [ARQ-1:0]              data_q;
    logic [REG_ADDR-1:0]         rd_q;

    // Load on acceptance, hold otherwise so the memory sees a stable request.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= OP_NOP;
            addr_q <= {MEMORY_ADDR_SIZE{1'b0}};
            data_q <= {ARQ{1'b0}};
            rd_q   <= {REG_ADDR{1'b0}};
        end else if (load_en_i) begin
            op_q   <= op_i;
            addr_q <= addr_i;
            data_q <= data_i;
            rd_q   <= rd_i;
        end else begin
            op_q   <= op_q;
            addr_q <= addr_q;
            data_q <= data_q;
            rd_q   <= rd_q;
        end
    end

    assign op_o   = op_q;
    assign addr_o = addr_q;
    assign data_o = data_q;
    assign rd_o   = rd_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: accepts EXE results, runs LOAD/STORE over a req/ack handshake with
// timeout, and produces the one-cycle register-file write-back.
module mem_wb_stage
    import rsaasip_pkg::*;
#(
    parameter int ARQ              = ARQ_DEF,
    parameter int MEMORY_ADDR_SIZE = MEMORY_ADDR_SIZE_DEF,
    parameter int REG_ADDR         = REG_ADDR_DEF,
    parameter int MEM_TIMEOUT      = MEM_TIMEOUT_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        exe_valid,
    output logic                        exe_ready,
    input  logic [1:0]                  exe_op,
    input  logic [ARQ-1:0]              exe_alu_result,
    input  logic [ARQ-1:0]              exe_store_data,
    input  logic [REG_ADDR-1:0]         exe_rd,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [MEMORY_ADDR_SIZE-1:0] mem_addr,
    output logic [ARQ-1:0]              mem_wdata,
    input  logic [ARQ-1:0]              mem_rdata,
    input  logic                        mem_ack,
    output logic [ARQ-1:0]              wb_result,
    output logic [REG_ADDR-1:0]         wb_rd,
    output logic                        wr_reg_en,
    output logic                        mem_err
);

    localparam logic [3:0] TIMEOUT_LAST = 4'(MEM_TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                mem_err_q, mem_err_d;
    logic [ARQ-1:0]      wb_result_q, wb_result_d;
    logic [REG_ADDR-1:0] wb_rd_q, wb_rd_d;

    mem_op_t             op_in_s;
    mem_op_t             hold_op_s;
    logic [ARQ-1:0]      hold_data_s;
    logic [REG_ADDR-1:0] hold_rd_s;
    logic                accept_s;
    logic                addr_bad_s;

    assign op_in_s    = mem_op_t'(exe_op);
    assign exe_ready  = (state_q != S_REQ);
    assign accept_s   = exe_valid && exe_ready;
    assign addr_bad_s = |exe_alu_result[ARQ-1:MEMORY_ADDR_SIZE];

    mem_wb_holdreg #(
        .ARQ              (ARQ),
        .MEMORY_ADDR_SIZE (MEMORY_ADDR_SIZE),
        .REG_ADDR         (REG_ADDR)
    ) u_holdreg (
        .clk       (clk),
        .rst       (rst),
        .load_en_i (accept_s),
        .op_i      (op_in_s),
        .addr_i    (exe_alu_result[MEMORY_ADDR_SIZE-1:0]),
        .data_i    (exe_store_data),
        .rd_i      (exe_rd),
        .op_o      (hold_op_s),
        .addr_o    (mem_addr),
        .data_o    (hold_data_s),
        .rd_o      (hold_rd_s)
    );

    // Next-state, wait counter, error pulse and write-back value selection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_err_d   = 1'b0;
        wb_result_d = wb_result_q;
        wb_rd_d     = wb_rd_q;
        case (state_q)
            S_IDLE, S_WB: begin
                state_d = S_IDLE;
                if (accept_s) begin
                    case (op_in_s)
                        OP_ALU: begin
                            state_d     = S_WB;
                            wb_result_d = exe_alu_result;
                            wb_rd_d     = exe_rd;
                        end
                        OP_LOAD, OP_STORE: begin
                            // Out-of-range address never reaches memory.
                            if (addr_bad_s) begin
                                mem_err_d = 1'b1;
                            end else begin
                                state_d = S_REQ;
                                cnt_d   = 4'd0;
                            end
                        end
                        default: begin
                            state_d = S_IDLE;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    if (hold_op_s == OP_LOAD) begin
                        state_d     = S_WB;
                        wb_result_d = mem_rdata;
                        wb_rd_d     = hold_rd_s;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = S_IDLE;
                    mem_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            mem_err_q   <= 1'b0;
            wb_result_q <= {ARQ{1'b0}};
            wb_rd_q     <= {REG_ADDR{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_err_q   <= mem_err_d;
            wb_result_q <= wb_result_d;
            wb_rd_q     <= wb_rd_d;
        end
    end

    assign mem_req   = (state_q == S_REQ);
    assign mem_we    = mem_req && (hold_op_s == OP_STORE);
    assign mem_wdata = mem_we ? hold_data_s : {ARQ{1'b0}};
    assign wr_reg_en = (state_q == S_WB);
    assign wb_result = wb_result_q;
    assign wb_rd     = wb_rd_q;
    assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Transaction-level bench for mem_wb_stage: directed cases followed by a random mix.
module tb_mem_wb_stage;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        exe_valid;
    logic        exe_ready;
    logic [1:0]  exe_op;
    logic [15:0] exe_alu_result;
    logic [15:0] exe_store_data;
    logic [3:0]  exe_rd;
    logic        mem_req;
    logic        mem_we;
    logic [12:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] wb_result;
    logic [3:0]  wb_rd;
    logic        wr_reg_en;
    logic        mem_err;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_wb_result;
    logic [3:0]  exp_wb_rd;

    mem_wb_stage dut (
        .clk            (clk),
        .rst            (rst),
        .exe_valid      (exe_valid),
        .exe_ready      (exe_ready),
        .exe_op         (exe_op),
        .exe_alu_result (exe_alu_result),
        .exe_store_data (exe_store_data),
        .exe_rd         (exe_rd),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .wb_result      (wb_result),
        .wb_rd          (wb_rd),
        .wr_reg_en      (wr_reg_en),
        .mem_err        (mem_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wb_hold(input string tag);
        check_eq({tag, "_wren"}, 32'(wr_reg_en), 32'd0);
        check_eq({tag, "_wbres"}, 32'(wb_result), 32'(exp_wb_result));
        check_eq({tag, "_wbrd"}, 32'(wb_rd), 32'(exp_wb_rd));
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] res,
                         input logic [15:0] sd, input logic [3:0] rd);
        exe_valid      = 1'b1;
        exe_op         = op;
        exe_alu_result = res;
        exe_store_data = sd;
        exe_rd         = rd;
        check_eq("ready_pre", 32'(exe_ready), 32'd1);
        tick();
        exe_valid = 1'b0;
    endtask

    task automatic tx_alu(input logic [15:0] res, input logic [3:0] rd);
        issue(2'b01, res, 16'h0000, rd);
        check_eq("alu_wren", 32'(wr_reg_en), 32'd1);
        check_eq("alu_wbres", 32'(wb_result), 32'(res));
        check_eq("alu_wbrd", 32'(wb_rd), 32'(rd));
        check_eq("alu_ready", 32'(exe_ready), 32'd1);
        check_eq("alu_req", 32'(mem_req), 32'd0);
        check_eq("alu_err", 32'(mem_err), 32'd0);
        exp_wb_result = res;
        exp_wb_rd     = rd;
    endtask

    task automatic tx_nop(input logic [15:0] res, input logic [3:0] rd);
        issue(2'b00, res, 16'h0000, rd);
        check_wb_hold("nop");
        check_eq("nop_req", 32'(mem_req), 32'd0);
        check_eq("nop_err", 32'(mem_err), 32'd0);
    endtask

    // delay = number of REQ cycles before the ack cycle; negative = never ack.
    task automatic tx_mem(input bit is_store, input logic [15:0] res, input logic [15:0] sd,
                          input logic [3:0] rd, input int delay, input logic [15:0] rdata);
        int n_wait;
        issue(is_store ? 2'b11 : 2'b10, res, sd, rd);
        if (res[15:13] != 3'b000) begin
            check_eq("oor_req", 32'(mem_req), 32'd0);
            check_eq("oor_err", 32'(mem_err), 32'd1);
            check_eq("oor_ready", 32'(exe_ready), 32'd1);
            check_wb_hold("oor");
            return;
        end
        n_wait = (delay >= 0 && delay < MAX_WAIT) ? delay + 1 : MAX_WAIT;
        for (int k = 0; k < n_wait; k++) begin
            check_eq("req_req", 32'(mem_req), 32'd1);
            check_eq("req_we", 32'(mem_we), 32'(is_store));
            check_eq("req_addr", 32'(mem_addr), 32'(res[12:0]));
            if (is_store) check_eq("req_wdata", 32'(mem_wdata), 32'(sd));
            check_eq("req_ready", 32'(exe_ready), 32'd0);
            check_eq("req_err", 32'(mem_err), 32'd0);
            check_eq("req_wren", 32'(wr_reg_en), 32'd0);
            if (delay >= 0 && k == delay) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end
            tick();
            mem_ack   = 1'b0;
            mem_rdata = 16'(32'($urandom));
        end
        check_eq("post_req", 32'(mem_req), 32'd0);
        check_eq("post_ready", 32'(exe_ready), 32'd1);
        if (delay < 0 || delay >= MAX_WAIT) begin
            check_eq("tmo_err", 32'(mem_err), 32'd1);
            check_wb_hold("tmo");
        end else if (is_store) begin
            check_eq("st_err", 32'(mem_err), 32'd0);
            check_wb_hold("st");
        end else begin
            check_eq("ld_err", 32'(mem_err), 32'd0);
            check_eq("ld_wren", 32'(wr_reg_en), 32'd1);
            check_eq("ld_wbres", 32'(wb_result), 32'(rdata));
            check_eq("ld_wbrd", 32'(wb_rd), 32'(rd));
            exp_wb_result = rdata;
            exp_wb_rd     = rd;
        end
    endtask

    task automatic gap(input int n, input bit stray_ack);
        exe_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            mem_ack = stray_ack;
            tick();
            mem_ack = 1'b0;
            check_wb_hold("gap");
            check_eq("gap_req", 32'(mem_req), 32'd0);
            check_eq("gap_err", 32'(mem_err), 32'd0);
            check_eq("gap_ready", 32'(exe_ready), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] r_res;
        int          r_delay;
        rst = 1'b1; exe_valid = 1'b0; exe_op = 2'b00; exe_alu_result = 16'h0000;
        exe_store_data = 16'h0000; exe_rd = 4'd0; mem_rdata = 16'h0000; mem_ack = 1'b0;
        exp_wb_result = 16'h0000; exp_wb_rd = 4'd0;
        tick(); tick();
        rst = 1'b0;
        check_eq("rst_ready", 32'(exe_ready), 32'd1);
        check_eq("rst_req", 32'(mem_req), 32'd0);
        check_eq("rst_we", 32'(mem_we), 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_wdata", 32'(mem_wdata), 32'd0);
        check_eq("rst_err", 32'(mem_err), 32'd0);
        check_wb_hold("rst");

        tx_alu(16'd17, 4'd3);
        tx_alu(16'd42, 4'd4);
        tx_alu(16'h5A5A, 4'd0);
        gap(1, 1'b0);
        tx_mem(1'b0, 16'h0010, 16'h0000, 4'd5, 3, 16'hBEEF);
        tx_mem(1'b0, 16'h0123, 16'h0000, 4'd6, 0, 16'hCAFE);
        tx_mem(1'b1, 16'h1FFF, 16'h1234, 4'd7, 0, 16'h0000);
        gap(1, 1'b1);
        tx_mem(1'b0, 16'h2000, 16'h0000, 4'd8, 0, 16'h0000);
        gap(1, 1'b0);
        tx_mem(1'b0, 16'h0444, 16'h0000, 4'd9, -1, 16'h0000);
        gap(1, 1'b0);
        tx_mem(1'b0, 16'h0555, 16'h0000, 4'd10, 14, 16'h7777);
        tx_nop(16'hFFFF, 4'd11);

        issue(2'b10, 16'h0020, 16'h0000, 4'd12);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_wb_result = 16'h0000;
        exp_wb_rd     = 4'd0;
        check_eq("rstreq_req", 32'(mem_req), 32'd0);
        check_eq("rstreq_ready", 32'(exe_ready), 32'd1);
        check_wb_hold("rstreq");
        mem_rdata = 16'hDEAD;
        gap(2, 1'b1);

        for (int t = 0; t < 60; t++) begin
            r_res   = 16'($urandom);
            r_delay = ($urandom_range(0, 9) == 9) ? -1 : int'($urandom_range(0, 5));
            case ($urandom_range(0, 3))
                0: tx_nop(r_res, 4'($urandom));
                1: tx_alu(r_res, 4'($urandom));
                default: begin
                    if ($urandom_range(0, 7) != 0) r_res[15:13] = 3'b000;
                    tx_mem($urandom_range(0, 1) == 1, r_res, 16'($urandom), 4'($urandom),
                           r_delay, 16'($urandom));
                end
            endcase
            gap($urandom_range(0, 2), $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
